// File: rtl/zx_mem_arbiter.sv
// Shares one single-port 64 KB RAM between the Z80 bus and the video fetch unit.
// Video has priority, but a CPU access waiting VID_MAX grants is served next.
module zx_mem_arbiter #(
    parameter int unsigned RAM_LAT  = 2,
    parameter logic [15:0] VID_BASE = 16'h4000,
    parameter logic [15:0] ROM_TOP  = 16'h4000,
    parameter int unsigned VID_MAX  = 4
) (
    input  logic        clk,
    input  logic        nRESET,
    input  logic        cpu_nmreq,
    input  logic        cpu_nrd,
    input  logic        cpu_nwr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_nwait,
    input  logic        vid_req,
    input  logic [12:0] vid_addr,
    output logic        vid_ack,
    output logic        vid_valid,
    output logic [7:0]  vid_data,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_wren,
    input  logic [7:0]  ram_q
);

    localparam int unsigned SW = (VID_MAX < 1) ? 1 : $clog2(VID_MAX + 1);
    localparam logic [2:0] LAT = 3'(RAM_LAT);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_VID_RD = 2'd1;
    localparam logic [1:0] S_CPU_RD = 2'd2;
    localparam logic [1:0] S_CPU_WR = 2'd3;

    logic [1:0]    r_state;
    logic [2:0]    r_cnt;
    logic [SW-1:0] r_starve;
    logic          r_served;

    logic          w_cpu_pend;
    logic          w_starve_max;
    logic [15:0]   w_vid_addr;

    // r_served masks the request until nMREQ rises, giving one RAM access per bus cycle.
    assign w_cpu_pend   = !cpu_nmreq && (!cpu_nrd || !cpu_nwr) && !r_served;
    assign cpu_nwait    = !w_cpu_pend;
    assign w_starve_max = (r_starve == SW'(VID_MAX));
    assign w_vid_addr   = VID_BASE + {3'b000, vid_addr};

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_starve  <= '0;
            r_served  <= 1'b0;
            cpu_rdata <= 8'hFF;
            vid_ack   <= 1'b0;
            vid_valid <= 1'b0;
            vid_data  <= 8'h00;
            ram_addr  <= 16'h0000;
            ram_wdata <= 8'h00;
            ram_wren  <= 1'b0;
        end else begin
            vid_ack   <= 1'b0;
            vid_valid <= 1'b0;
            ram_wren  <= 1'b0;
            if (cpu_nmreq) begin
                r_served <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (vid_req && !(w_cpu_pend && w_starve_max)) begin
                        r_state  <= S_VID_RD;
                        ram_addr <= w_vid_addr;
                        vid_ack  <= 1'b1;
                        r_starve <= w_cpu_pend ? r_starve + 1'b1 : '0;
                    end else if (w_cpu_pend && !cpu_nrd) begin
                        // A cycle with both nRD and nWR low is treated as a read.
                        r_state  <= S_CPU_RD;
                        ram_addr <= cpu_addr;
                        r_starve <= '0;
                    end else if (w_cpu_pend) begin
                        r_state   <= S_CPU_WR;
                        ram_addr  <= cpu_addr;
                        ram_wdata <= cpu_wdata;
                        ram_wren  <= (cpu_addr >= ROM_TOP);
                        r_starve  <= '0;
                    end else begin
                        r_starve <= '0;
                    end
                end

                S_VID_RD: begin
                    if (r_cnt == LAT) begin
                        vid_data  <= ram_q;
                        vid_valid <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                S_CPU_RD: begin
                    if (r_cnt == LAT) begin
                        cpu_rdata <= ram_q;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                        if (!cpu_nmreq) begin
                            r_served <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end

                S_CPU_WR: begin
                    r_state <= S_IDLE;
                    if (!cpu_nmreq) begin
                        r_served <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Directed bench for zx_mem_arbiter: video fetch, CPU read/write, ROM guard,
// starvation guard, video/CPU ordering and asynchronous reset mid-access.
module tb_zx_mem_arbiter;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        cpu_nmreq, cpu_nrd, cpu_nwr;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_nwait;
    logic        vid_req;
    logic [12:0] vid_addr;
    logic        vid_ack, vid_valid;
    logic [7:0]  vid_data;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wren;
    logic [7:0]  ram_q;

    int total = 0;
    int bad   = 0;

    zx_mem_arbiter #(
        .RAM_LAT (2),
        .VID_BASE(16'h4000),
        .ROM_TOP (16'h4000),
        .VID_MAX (4)
    ) dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .cpu_nmreq(cpu_nmreq),
        .cpu_nrd  (cpu_nrd),
        .cpu_nwr  (cpu_nwr),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_nwait(cpu_nwait),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_ack  (vid_ack),
        .vid_valid(vid_valid),
        .vid_data (vid_data),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_nmreq = 1'b1;
        cpu_nrd   = 1'b1;
        cpu_nwr   = 1'b1;
    endtask

    task automatic test_reset();
        nRESET = 1'b1;
        cpu_idle();
        cpu_addr = 16'h0000; cpu_wdata = 8'h00;
        vid_req = 1'b0; vid_addr = 13'h0000; ram_q = 8'h00;
        #2 nRESET = 1'b0;
        #1;
        total++; if (cpu_rdata !== 8'hFF) begin bad++; $display("FAIL rst_cpu_rdata got=%h want=ff", cpu_rdata); end
        total++; if (cpu_nwait !== 1'b1) begin bad++; $display("FAIL rst_cpu_nwait got=%b want=1", cpu_nwait); end
        total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL rst_vid_ack got=%b want=0", vid_ack); end
        total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL rst_vid_valid got=%b want=0", vid_valid); end
        total++; if (vid_data !== 8'h00) begin bad++; $display("FAIL rst_vid_data got=%h want=00", vid_data); end
        total++; if (ram_addr !== 16'h0000) begin bad++; $display("FAIL rst_ram_addr got=%h want=0000", ram_addr); end
        total++; if (ram_wdata !== 8'h00) begin bad++; $display("FAIL rst_ram_wdata got=%h want=00", ram_wdata); end
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rst_ram_wren got=%b want=0", ram_wren); end
        tick(); tick();
        nRESET = 1'b1;
        tick();
    endtask

    task automatic test_video();
        vid_req = 1'b1; vid_addr = 13'h0005; ram_q = 8'hA5;
        tick();
        total++; if (vid_ack !== 1'b1) begin bad++; $display("FAIL vid_ack_grant got=%b want=1", vid_ack); end
        total++; if (ram_addr !== 16'h4005) begin bad++; $display("FAIL vid_ram_addr got=%h want=4005", ram_addr); end
        vid_req = 1'b0;
        tick();
        total++; if (vid_ack !== 1'b0) begin bad++; $display("FAIL vid_ack_one_cycle got=%b want=0", vid_ack); end
        total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL vid_valid_early1 got=%b want=0", vid_valid); end
        tick();
        total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL vid_valid_early2 got=%b want=0", vid_valid); end
        tick();
        total++; if (vid_valid !== 1'b1) begin bad++; $display("FAIL vid_valid_pulse got=%b want=1", vid_valid); end
        total++; if (vid_data !== 8'hA5) begin bad++; $display("FAIL vid_data got=%h want=a5", vid_data); end
        ram_q = 8'h00;
        tick();
        total++; if (vid_valid !== 1'b0) begin bad++; $display("FAIL vid_valid_end got=%b want=0", vid_valid); end
        total++; if (vid_data !== 8'hA5) begin bad++; $display("FAIL vid_data_hold got=%h want=a5", vid_data); end
    endtask

    task automatic test_cpu_read();
        logic extra;
        cpu_addr = 16'h8000; cpu_nmreq = 1'b0; cpu_nrd = 1'b0; ram_q = 8'h3C;
        #1;
        total++; if (cpu_nwait !== 1'b0) begin bad++; $display("FAIL rd_nwait_comb got=%b want=0", cpu_nwait); end
        tick();
        total++; if (ram_addr !== 16'h8000) begin bad++; $display("FAIL rd_ram_addr got=%h want=8000", ram_addr); end
        tick(); tick();
        total++; if (cpu_nwait !== 1'b0) begin bad++; $display("FAIL rd_nwait_pending got=%b want=0", cpu_nwait); end
        tick();
        total++; if (cpu_nwait !== 1'b1) begin bad++; $display("FAIL rd_nwait_done got=%b want=1", cpu_nwait); end
        total++; if (cpu_rdata !== 8'h3C) begin bad++; $display("FAIL rd_cpu_rdata got=%h want=3c", cpu_rdata); end
        // A second read in the same bus cycle would pick up this new value.
        ram_q = 8'h99;
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cpu_nwait !== 1'b1 || cpu_rdata !== 8'h3C) extra = 1'b1;
        end
        total++; if (extra !== 1'b0) begin bad++; $display("FAIL rd_single_access got=%b want=0 (rdata=%h nwait=%b)", extra, cpu_rdata, cpu_nwait); end
        cpu_idle();
        tick();
        cpu_nmreq = 1'b0; cpu_nrd = 1'b0; ram_q = 8'h5A;
        #1;
        total++; if (cpu_nwait !== 1'b0) begin bad++; $display("FAIL rd_new_cycle_nwait got=%b want=0", cpu_nwait); end
        tick(); tick(); tick(); tick();
        total++; if (cpu_rdata !== 8'h5A) begin bad++; $display("FAIL rd_new_cycle_rdata got=%h want=5a", cpu_rdata); end
        cpu_idle();
        tick();
    endtask

    task automatic test_cpu_write();
        logic seen;
        cpu_addr = 16'h1234; cpu_wdata = 8'h77; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
        seen = 1'b0;
        #1;
        total++; if (cpu_nwait !== 1'b0) begin bad++; $display("FAIL wr_rom_nwait_low got=%b want=0", cpu_nwait); end
        tick(); if (ram_wren) seen = 1'b1;
        tick(); if (ram_wren) seen = 1'b1;
        total++; if (cpu_nwait !== 1'b1) begin bad++; $display("FAIL wr_rom_nwait_high got=%b want=1", cpu_nwait); end
        for (int i = 0; i < 3; i++) begin
            tick(); if (ram_wren) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL wr_rom_blocked got=%b want=0", seen); end
        cpu_idle();
        tick();
        cpu_addr = 16'h5000; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
        tick();
        total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL wr_ram_wren got=%b want=1", ram_wren); end
        total++; if (ram_addr !== 16'h5000) begin bad++; $display("FAIL wr_ram_addr got=%h want=5000", ram_addr); end
        total++; if (ram_wdata !== 8'h77) begin bad++; $display("FAIL wr_ram_wdata got=%h want=77", ram_wdata); end
        tick();
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL wr_wren_one_cycle got=%b want=0", ram_wren); end
        total++; if (cpu_nwait !== 1'b1) begin bad++; $display("FAIL wr_nwait_done got=%b want=1", cpu_nwait); end
        cpu_idle();
        tick();
    endtask

    task automatic test_starve();
        int acks;
        int cyc;
        vid_req = 1'b1; vid_addr = 13'h0010; ram_q = 8'hC3;
        cpu_addr = 16'h8001; cpu_nmreq = 1'b0; cpu_nrd = 1'b0;
        acks = 0; cyc = 0;
        do begin
            tick(); cyc++;
            if (vid_ack) acks++;
        end while (cpu_nwait !== 1'b1 && cyc < 60);
        total++; if (cyc >= 60) begin bad++; $display("FAIL starve_timeout1 got=%0d want<60", cyc); end
        total++; if (acks !== 4) begin bad++; $display("FAIL starve_grants1 got=%0d want=4", acks); end
        total++; if (cpu_rdata !== 8'hC3) begin bad++; $display("FAIL starve_rdata got=%h want=c3", cpu_rdata); end
        cpu_idle();
        tick();
        // Counter must restart from zero: again four video grants before the CPU.
        cpu_nmreq = 1'b0; cpu_nrd = 1'b0; ram_q = 8'h6B;
        acks = 0; cyc = 0;
        do begin
            tick(); cyc++;
            if (vid_ack) acks++;
        end while (cpu_nwait !== 1'b1 && cyc < 60);
        total++; if (cyc >= 60) begin bad++; $display("FAIL starve_timeout2 got=%0d want<60", cyc); end
        total++; if (acks !== 4) begin bad++; $display("FAIL starve_grants2 got=%0d want=4", acks); end
        total++; if (cpu_rdata !== 8'h6B) begin bad++; $display("FAIL starve_rdata2 got=%h want=6b", cpu_rdata); end
        vid_req = 1'b0;
        cpu_idle();
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_back_to_back();
        vid_req = 1'b1; vid_addr = 13'h0020; ram_q = 8'h11;
        cpu_addr = 16'h6000; cpu_wdata = 8'h5E; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
        tick();
        total++; if (vid_ack !== 1'b1) begin bad++; $display("FAIL b2b_vid_first got=%b want=1", vid_ack); end
        total++; if (ram_addr !== 16'h4020) begin bad++; $display("FAIL b2b_vid_addr got=%h want=4020", ram_addr); end
        vid_req = 1'b0;
        tick(); tick(); tick();
        total++; if (vid_valid !== 1'b1) begin bad++; $display("FAIL b2b_vid_valid got=%b want=1", vid_valid); end
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL b2b_wren_early got=%b want=0", ram_wren); end
        tick();
        total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL b2b_cpu_write got=%b want=1", ram_wren); end
        total++; if (ram_addr !== 16'h6000) begin bad++; $display("FAIL b2b_cpu_addr got=%h want=6000", ram_addr); end
        total++; if (ram_wdata !== 8'h5E) begin bad++; $display("FAIL b2b_cpu_wdata got=%h want=5e", ram_wdata); end
        tick();
        total++; if (cpu_nwait !== 1'b1) begin bad++; $display("FAIL b2b_nwait_done got=%b want=1", cpu_nwait); end
        cpu_idle();
        tick();
    endtask

    task automatic test_reset_mid();
        logic seen;
        vid_req = 1'b1; vid_addr = 13'h0007; ram_q = 8'hEE;
        tick();
        vid_req = 1'b0;
        tick();
        nRESET = 1'b0;
        #1;
        total++; if (ram_addr !== 16'h0000) begin bad++; $display("FAIL rmid_ram_addr got=%h want=0000", ram_addr); end
        total++; if (vid_data !== 8'h00) begin bad++; $display("FAIL rmid_vid_data got=%h want=00", vid_data); end
        total++; if (cpu_rdata !== 8'hFF) begin bad++; $display("FAIL rmid_cpu_rdata got=%h want=ff", cpu_rdata); end
        total++; if (ram_wdata !== 8'h00) begin bad++; $display("FAIL rmid_ram_wdata got=%h want=00", ram_wdata); end
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); if (vid_valid || vid_ack) seen = 1'b1;
        end
        nRESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); if (vid_valid || vid_ack) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_no_vid_valid got=%b want=0", seen); end
        vid_req = 1'b1; vid_addr = 13'h0008; ram_q = 8'h42;
        tick();
        total++; if (vid_ack !== 1'b1 || ram_addr !== 16'h4008) begin bad++; $display("FAIL rmid_fresh_grant got=%b/%h want=1/4008", vid_ack, ram_addr); end
        vid_req = 1'b0;
        tick(); tick(); tick();
        total++; if (vid_valid !== 1'b1 || vid_data !== 8'h42) begin bad++; $display("FAIL rmid_fresh_data got=%b/%h want=1/42", vid_valid, vid_data); end
        tick();
        // Reset during the write cycle must drop ram_wren without waiting for a clock.
        cpu_addr = 16'h5000; cpu_wdata = 8'h33; cpu_nmreq = 1'b0; cpu_nwr = 1'b0;
        tick();
        total++; if (ram_wren !== 1'b1) begin bad++; $display("FAIL rmid_wr_start got=%b want=1", ram_wren); end
        #2 nRESET = 1'b0;
        #1;
        total++; if (ram_wren !== 1'b0) begin bad++; $display("FAIL rmid_wren_async got=%b want=0", ram_wren); end
        cpu_idle();
        tick();
        nRESET = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_video();
        test_cpu_read();
        test_cpu_write();
        test_starve();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
